// File: rtl/tone_synth_pkg.sv
// Shared types and derived constants for the tone synthesiser.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int ENV_MAX   = 255;
  localparam int AMP_BITS  = 8;

  function automatic int unsigned half_of(input int unsigned clk_hz);
    return clk_hz / 2;
  endfunction

  function automatic int unsigned tick_div_of(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tone_synth_pwm_dac.sv
// 8-bit free-running PWM: output high while the counter is below the sample.
module pwm_dac
  import tone_synth_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [AMP_BITS-1:0] sample,
  output logic                pwm_out
);

  logic [AMP_BITS-1:0] p_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg   <= '0;
      pwm_out <= 1'b0;
    end else begin
      p_reg   <= p_reg + 1'b1;
      pwm_out <= (p_reg < sample);
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator with linear attack/release envelope,
// producing an 8-bit sample stream and a PWM speaker output.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 48_000,
  parameter int unsigned AMP_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      freq,
  input  logic [15:0]      arm_rate,
  output logic [AMP_W-1:0] sample,
  output logic             sample_valid,
  output logic             pwm_out,
  output logic             busy
);

  localparam logic [31:0]      HALF      = half_of(CLK_HZ);
  localparam int unsigned      TICK_DIV  = tick_div_of(CLK_HZ, TICK_HZ);
  localparam int               TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AMP_W-1:0] ENV_TOP   = AMP_W'(ENV_MAX);

  state_t           state_reg;
  logic [AMP_W-1:0] env_reg;
  logic [31:0]      acc_reg;
  logic             sq_reg;
  logic [TW-1:0]    tick_cnt_reg;
  logic [15:0]      act_freq_reg;
  logic [15:0]      act_rate_reg;
  logic [15:0]      step_cnt_reg;

  logic        tick;
  logic        step;
  logic [31:0] acc_sum;

  assign tick    = (tick_cnt_reg == TICK_LAST);
  assign step    = tick && (step_cnt_reg >= act_rate_reg - 16'd1);
  assign acc_sum = acc_reg + {16'd0, act_freq_reg};

  // Latched note parameters hold through release so it sounds at the last pitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_freq_reg <= '0;
      act_rate_reg <= 16'd1;
    end else if (freq != 16'd0) begin
      act_freq_reg <= freq;
      act_rate_reg <= (arm_rate == 16'd0) ? 16'd1 : arm_rate;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  // Phase accumulator toggles the square each time it crosses half a clock-second.
  always_ff @(posedge clk) begin
    if (reset || state_reg == IDLE) begin
      acc_reg <= '0;
      sq_reg  <= 1'b0;
    end else if (act_freq_reg != 16'd0) begin
      if (acc_sum >= HALF) begin
        acc_reg <= acc_sum - HALF;
        sq_reg  <= ~sq_reg;
      end else begin
        acc_reg <= acc_sum;
      end
    end
  end

  // Transitions override the default step-counter update and drop any env step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      env_reg      <= '0;
      step_cnt_reg <= '0;
      busy         <= 1'b0;
    end else begin
      if (tick)
        step_cnt_reg <= step ? 16'd0 : step_cnt_reg + 16'd1;
      case (state_reg)
        IDLE: begin
          if (freq != 16'd0) begin
            state_reg    <= ATTACK;
            busy         <= 1'b1;
            step_cnt_reg <= '0;
          end
        end
        ATTACK: begin
          if (freq == 16'd0) begin
            state_reg    <= RELEASE;
            step_cnt_reg <= '0;
          end else if (env_reg == ENV_TOP) begin
            state_reg    <= SUSTAIN;
            step_cnt_reg <= '0;
          end else if (step) begin
            env_reg <= env_reg + 1'b1;
            if (env_reg == ENV_TOP - 1'b1) begin
              state_reg    <= SUSTAIN;
              step_cnt_reg <= '0;
            end
          end
        end
        SUSTAIN: begin
          env_reg <= ENV_TOP;
          if (freq == 16'd0) begin
            state_reg    <= RELEASE;
            step_cnt_reg <= '0;
          end
        end
        RELEASE: begin
          if (freq != 16'd0) begin
            state_reg    <= ATTACK;
            step_cnt_reg <= '0;
          end else if (env_reg == '0) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            step_cnt_reg <= '0;
          end else if (step) begin
            env_reg <= env_reg - 1'b1;
            if (env_reg == AMP_W'(1)) begin
              state_reg    <= IDLE;
              busy         <= 1'b0;
              step_cnt_reg <= '0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick;
      if (tick)
        sample <= sq_reg ? env_reg : '0;
    end
  end

  pwm_dac u_pwm_dac (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample),
    .pwm_out (pwm_out)
  );

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
Downstream consumer of the key decoder's frequency/rate pair (freq in Hz, arm_rate envelope step interval). Generates a square-wave tone at freq Hz with a linear attack/release amplitude envelope. Emits an 8-bit sample stream and a 1-bit PWM audio output for the board's speaker pin. Sits between the key decoder and the audio output pin.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
TICK_HZ, 48_000, sample/envelope tick rate in Hz; CLK_HZ/TICK_HZ must be an integer >= 2
AMP_W, 8, envelope/sample width; fixed at 8 for the PWM sub-module

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
freq  in  16  requested tone frequency in Hz; 0 = no key pressed
arm_rate  in  16  envelope step interval in sample ticks; 0 treated as 1
sample  out  8  current unsigned sample (square ? env : 0)
sample_valid  out  1  one-clock pulse when sample updates
pwm_out  out  1  PWM-encoded sample
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync, high): state=IDLE; env=0; acc=0; sq=0; tick counter=0; act_freq=0; act_rate=1; sample=0; sample_valid=0; pwm counter=0; pwm_out=0; busy=0. Reset asserted mid-note aborts immediately, with no release phase.
- Inputs are sampled every clk; no synchronizer is needed (same clock domain as the decoder).
- Latch: whenever freq!=0, act_freq<=freq and act_rate<=(arm_rate==0 ? 1 : arm_rate) on that clk. When freq==0, the latches hold, so the release sounds at the last note.
- Tone: every clk with act_freq!=0, compute acc+act_freq.
  - If the sum >= HALF=CLK_HZ/2: acc<=sum-HALF and sq toggles. Otherwise acc<=sum.
  - acc width is 32 bits, with no overflow because HALF+65535 < 2^32.
  - Result: square period = CLK_HZ/act_freq clocks, exact on average. In IDLE, acc=0 and sq=0.
- Tick: counter 0..TICK_DIV-1 (TICK_DIV=CLK_HZ/TICK_HZ); tick=1 for the one clk when counter==TICK_DIV-1. Free-running from reset.
- Envelope step counter: counts ticks 0..act_rate-1; a step fires on the tick where the count reaches act_rate-1. The count resets to 0 on every state transition.
- FSM, evaluated every clk, with transitions taking effect the next clk:
  - IDLE: freq!=0 -> ATTACK.
  - ATTACK: on step, env<=env+1. When env reaches 255 -> SUSTAIN. freq==0 -> RELEASE (env held).
  - SUSTAIN: env=255. freq==0 -> RELEASE.
  - RELEASE: on step, env<=env-1. When env reaches 0 -> IDLE. freq!=0 -> ATTACK from the current env, with no reset to 0 (click-free retrigger).
  - A note change (freq nonzero to a different nonzero value) does not change state. act_freq updates and acc is not cleared.
  - If a step and a freq transition fall on the same clk, the transition wins; the env step is dropped.
  - env saturates at 0 and 255 and never wraps.
- Sample: on the clk after tick, sample<=(sq ? env : 0) and sample_valid=1 for exactly that clk (latency 1 clk from tick).
- PWM: 8-bit free-running counter p incremented every clk; pwm_out registered = (p < sample). sample=0 gives constant 0; sample=255 gives 255/256 duty.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package tone_synth_pkg:
  - state enum {IDLE, ATTACK, SUSTAIN, RELEASE} (2-bit)
  - function/constants for HALF=CLK_HZ/2 and TICK_DIV=CLK_HZ/TICK_HZ
  - ENV_MAX=255
- One sub-module: pwm_dac (8-bit counter + compare, inputs clk/reset/sample, output pwm_out).
- Phase accumulator, tick generator and FSM stay in tone_synth.

Test Plan (all with CLK_HZ=1_000_000, TICK_HZ=100_000, so TICK_DIV=10 and HALF=500_000):
- Reset mid-SUSTAIN with freq=1000 -> next clk: sample=0, busy=0, pwm_out=0, sq=0. After release, with freq still 1000, ATTACK restarts from env=0.
- freq=1000, arm_rate=2 held -> sq toggles every 500 clks (period 1000). env increments every 20 clks and reaches 255 at 5100±10 clks after press; state=SUSTAIN. sample alternates 255/0 in 500-clk halves.
- From SUSTAIN, freq->0 with arm_rate input changed to 7 -> release uses latched rate 2. env=0 after 5100±10 clks, then IDLE and busy=0. Tone continues at 1000 Hz during release.
- Press freq=1046, release after env=100, re-press freq=1318 -> ATTACK resumes at env=100 (no drop to 0). Square period switches to ~758.7 clks average, with a 1000-press count error < 1 clk.
- arm_rate=0, freq=1396 -> behaves as rate 1: env=255 at 2550±10 clks. sample_valid pulses exactly every 10 clks, one clk wide.
- Force sample=0 and sample=255 (via env at IDLE and at SUSTAIN with sq=1) -> pwm_out duty 0/256 and 255/256 over a 256-clk window.
